// File: rtl/spi_slave_pkg.sv
// Shared types and register map for the SPI keycode target.
// Optional build macro: SPI_FRAME_CNT_EN (frame counter at address 2,
// STATUS moves to address 3, ID becomes unreadable).
`timescale 1ns/1ps
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_KEYCODE = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
`ifdef SPI_FRAME_CNT_EN
  localparam logic [1:0] ADDR_FCNT    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;
`else
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_ID      = 2'd3;
`endif

  // STATUS = {5'b0, overrun, abort, 1'b0}
  localparam int STAT_ABORT_BIT   = 1;
  localparam int STAT_OVERRUN_BIT = 2;

  function automatic logic [7:0] pack_status(input logic overrun, input logic abort);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_OVERRUN_BIT] = overrun;
    s[STAT_ABORT_BIT]   = abort;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous input plus single-cycle
// rise/fall pulses taken from one extra flop behind the synchronizer.
// Every stage resets to 0, so a line held low through reset release
// produces no edge.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain and edge-detect history flop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_keycode_slave.sv
// SPI mode-0 target decoding 16-bit frames {R/W, 5 ignored, addr[1:0], data[7:0]}
// into a four-entry register file (KEYCODE, CTRL, STATUS, ID).
// Optional build macro: SPI_FRAME_CNT_EN adds a completed-frame counter.
`timescale 1ns/1ps
module spi_keycode_slave
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCLK,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_oe,
  output logic [7:0] keycode,
  output logic       keycode_strobe,
  output logic [7:0] ctrl
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sigs;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(Clk), .rst_ni(Reset_n), .d_i(SCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk_i(Clk), .rst_ni(Reset_n), .d_i(SS_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  // MOSI only needs the synchronized level; it is sampled on SCLK rise pulses
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(Clk), .rst_ni(Reset_n), .d_i(MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sigs = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_t     state_q;
  logic [2:0] bitcnt_q;
  logic [7:0] byte_q;
  logic       cmd_rw_q;
  logic [1:0] cmd_addr_q;
  logic [7:0] miso_sr_q;
  logic       miso_q;
  logic       oe_q;
  logic       armed_q;
  logic [7:0] keycode_q;
  logic [7:0] ctrl_q;
  logic       keycode_strobe_q;
  logic       overrun_q;
  logic       abort_q;
`ifdef SPI_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;
`endif

  logic [7:0] byte_d;
  logic [7:0] rd_data_d;

  // Register read mux; the value is snapshotted into the shift register
  function automatic logic [7:0] read_mux(input logic [1:0] addr);
    logic [7:0] r;
    r = 8'h00;
    case (addr)
      ADDR_KEYCODE: r = keycode_q;
      ADDR_CTRL:    r = ctrl_q;
      ADDR_STATUS:  r = pack_status(overrun_q, abort_q);
`ifdef SPI_FRAME_CNT_EN
      ADDR_FCNT:    r = frame_cnt_q;
`else
      ADDR_ID:      r = ID_VALUE;
`endif
      default:      r = 8'h00;
    endcase
    return r;
  endfunction

  // Incoming byte including the bit sampled on the current SCLK rise
  always_comb begin
    byte_d    = {byte_q[6:0], mosi_lvl};
    rd_data_d = read_mux(byte_d[1:0]);
  end

  // Frame FSM, register file and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= IDLE;
      bitcnt_q         <= 3'd0;
      byte_q           <= 8'h00;
      cmd_rw_q         <= 1'b0;
      cmd_addr_q       <= 2'd0;
      miso_sr_q        <= 8'h00;
      miso_q           <= 1'b0;
      oe_q             <= 1'b0;
      armed_q          <= 1'b0;
      keycode_q        <= 8'h00;
      ctrl_q           <= 8'h00;
      keycode_strobe_q <= 1'b0;
      overrun_q        <= 1'b0;
      abort_q          <= 1'b0;
`ifdef SPI_FRAME_CNT_EN
      frame_cnt_q      <= 8'h00;
`endif
    end else begin
      keycode_strobe_q <= 1'b0;
      // A select that was already low at reset release must go high once
      // before any frame is accepted or MISO is driven.
      if (ss_lvl) armed_q <= 1'b1;
      oe_q <= armed_q & ~ss_lvl;

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall && armed_q) begin
            state_q  <= CMD;
            bitcnt_q <= 3'd0;
          end
        end

        CMD: begin
          if (ss_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_rise) begin
            byte_q   <= byte_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              cmd_rw_q   <= byte_d[7];
              cmd_addr_q <= byte_d[1:0];
              miso_sr_q  <= rd_data_d;
              miso_q     <= rd_data_d[7];
              state_q    <= DATA;
            end
          end
        end

        DATA: begin
          if (ss_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_rise) begin
            byte_q   <= byte_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= DONE;
              miso_q  <= 1'b0;
              if (cmd_rw_q) begin
                if (cmd_addr_q == ADDR_KEYCODE) begin
                  keycode_q        <= byte_d;
                  keycode_strobe_q <= 1'b1;
                end else if (cmd_addr_q == ADDR_CTRL) begin
                  ctrl_q <= byte_d;
                end
              end else if (cmd_addr_q == ADDR_STATUS) begin
                overrun_q <= 1'b0;
                abort_q   <= 1'b0;
              end
`ifdef SPI_FRAME_CNT_EN
              frame_cnt_q <= frame_cnt_q + 8'd1;
`endif
            end
          end else if (sclk_fall && bitcnt_q != 3'd0) begin
            // The fall right after the 8th rise keeps data[7] on the line
            miso_q    <= miso_sr_q[6];
            miso_sr_q <= {miso_sr_q[6:0], 1'b0};
          end
        end

        DONE: begin
          miso_q <= 1'b0;
          if (ss_rise) begin
            state_q <= IDLE;
          end else if (sclk_rise) begin
            overrun_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO           = miso_q;
  assign MISO_oe        = oe_q;
  assign keycode        = keycode_q;
  assign keycode_strobe = keycode_strobe_q;
  assign ctrl           = ctrl_q;

endmodule
